rxstr: RTL
==========

# rxstr

Serial receiver and keyword detector, the receive-side counterpart of the string transmitter. It deserialises 8N1 UART frames from `rx`, presents each byte with a one-cycle strobe and flags framing errors. It keeps a sliding history of the last `PATLEN` bytes and pulses `match` whenever that history equals the compiled-in keyword. It sits directly behind the FPGA RX pin and drives command or trigger logic.

## Interface
- `BAUDRATE`, default `` `B115200 `` (from baudgen.vh): clock cycles per bit period; minimum 4.
- `PATLEN`, default 4: keyword length in bytes, 1..16.
- `PATTERN`, default "Hola": keyword as `8*PATLEN` bits. The first character is the MSB byte.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `data` out 8: last correctly framed byte. Holds its value until the next valid frame.
- `rcv` out 1: one-cycle pulse when `data` is updated.
- `match` out 1: one-cycle pulse, coincident with `rcv`, when the keyword has been received.
- `ferr` out 1: one-cycle pulse on a framing error (stop bit sampled low).
- `busy` out 1: high from start-bit detection to the end of the frame.

## Operation
- `rx` passes through a 2-flop synchroniser; all logic below uses the synchronised value `rxs`.
- There is one baud counter, wide enough for `BAUDRATE-1`. A "tick" means the counter reaching 0; the counter reloads on each tick.
- FSM states:
  - IDLE: on a falling edge of `rxs`, load the counter with `BAUDRATE/2 - 1` and go to START.
  - START: at the tick, if `rxs`=0 go to DATA with the counter reloaded to `BAUDRATE-1`. Otherwise it is a glitch: return to IDLE with no output.
  - DATA: sample `rxs` at each tick and shift it in LSB-first. After 8 samples go to STOP.
  - STOP: at the tick, if `rxs`=1, latch the shift register into `data`, pulse `rcv` and return to IDLE. If `rxs`=0, pulse `ferr` and go to BREAK; `data` and the history are unchanged.
  - BREAK: wait for `rxs`=1, then go to IDLE. A line held low never produces repeated frames.
- `busy` is high in START, DATA, STOP and BREAK.
- History: a shift register of `PATLEN` bytes. On each valid byte, the new byte enters the LSB byte.
- Fill counter: saturates at `PATLEN`. It prevents a match against reset contents.
- `match` = valid byte this cycle AND fill ≥ `PATLEN` (counting the new byte) AND updated history == `PATTERN`.
- Overlapping occurrences all match. For example, keyword "aa" on input "aaa" gives 2 matches.
- Reset: FSM to IDLE, synchroniser flops to 1, history and fill cleared. Outputs reset to `data`=0x00, `rcv`=0, `match`=0, `ferr`=0, `busy`=0.
- Reset mid-frame discards the partial byte. The first falling edge after reset release starts a new frame.

## Timing
- Start-bit edge seen on `rxs` 2–3 clocks after the `rx` edge.
- Sample points fall at `BAUDRATE/2 + k*BAUDRATE` clocks after the `rxs` falling edge, for k=1..8 (data) and k=9 (stop).
- `rcv`, `match` and `ferr` are registered and assert the clock after the stop sample.
- `busy` falls in that same cycle, except after a framing error, where it stays high through BREAK.
- Back-to-back frames: IDLE is re-entered half a bit before the next start edge, so zero idle bits between frames are supported.

## Configuration
- `RXSTR_NOCASE_EN`:
  - Defined: the received byte and the `PATTERN` bytes have ASCII 'a'..'z' folded to 'A'..'Z' before comparison only. `data` always carries the raw byte.
  - Undefined: comparison is exact, 8-bit.

## Test plan
- Reset released, send 0x55 at `BAUDRATE`=104 → one `rcv` pulse, `data`=0x55, `ferr`=0, `match`=0.
- Send "xHola" back-to-back → 5 `rcv` pulses; `match` only with the final 'a' (0x61).
- Send "Hol" then assert `rst` mid-frame of 'a', release, send "a" → no `match`. Then send "Hola" → `match` once.
- Send a frame with stop bit 0 (line held low for 20 bit times) → one `ferr`, no `rcv`, `busy` high until `rx` returns high. Then send 0x41 → `data`=0x41.
- Drive a 30-clock low glitch on idle `rx` → no `rcv`/`ferr`, back in IDLE (`busy`=0) within 60 clocks.
- With `RXSTR_NOCASE_EN` defined, send "HOLA" → `match`=1 on the last byte. Without the macro → no `match`.

Source files
------------

// File: rtl/rxstr.sv
// rxstr - 8N1 UART receiver with keyword detector.
//
// Deserialises frames from the rx pin. Each correctly framed byte is presented
// on data with a one-cycle rcv strobe. A stop bit sampled low pulses ferr and
// parks the receiver until the line returns high. The receiver keeps a sliding
// history of the last PATLEN bytes and pulses match, together with rcv, when
// that history equals PATTERN.
//
// Parameters:
//   BAUDRATE  clock cycles per bit period (minimum 4), default `B115200
//   PATLEN    keyword length in bytes, 1..16
//   PATTERN   keyword, first character in the most significant byte
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   rx     serial line, idle high, asynchronous to clk
//   data   last correctly framed byte, held until the next valid frame
//   rcv    one-cycle pulse when data is updated
//   match  one-cycle pulse with rcv when the keyword has just been completed
//   ferr   one-cycle pulse on a framing error
//   busy   high from start-bit detection to the end of the frame
// Configuration macro:
//   RXSTR_NOCASE_EN  when defined, the keyword comparison folds ASCII a..z to
//                    A..Z on both sides; data always carries the raw byte.

`ifndef B115200
`define B115200 104
`endif

module rxstr #(
    parameter int                  BAUDRATE = `B115200,
    parameter int                  PATLEN   = 4,
    parameter logic [8*PATLEN-1:0] PATTERN  = "Hola"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       match,
    output logic       ferr,
    output logic       busy
);

    localparam int            CW   = $clog2(BAUDRATE);
    localparam logic [CW-1:0] FULL = CW'(BAUDRATE - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUDRATE / 2 - 1);
    localparam int            FW   = $clog2(PATLEN + 1);
    // The oldest byte falls off on the next shift, so between frames only
    // PATLEN-1 bytes are worth keeping; the new byte completes the window.
    localparam int            HW   = (PATLEN > 1) ? 8 * (PATLEN - 1) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state_reg, state_next;
    logic            rx_meta_reg, rxs_reg, rxs_prev_reg;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bits_reg, bits_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      data_reg, data_next;
    logic            rcv_reg, rcv_next;
    logic            match_reg, match_next;
    logic            ferr_reg, ferr_next;
    logic [HW-1:0]   hist_reg, hist_next;
    logic [FW-1:0]   fill_reg, fill_next;

    logic                tick;
    logic [FW-1:0]       fill_sat;
    logic [8*PATLEN-1:0] window;
    logic [PATLEN-1:0]   byte_eq;
    logic                hist_eq;

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef RXSTR_NOCASE_EN
        return (b >= 8'h61 && b <= 8'h7a) ? (b - 8'h20) : b;
`else
        return b;
`endif
    endfunction

    assign tick = (cnt_reg == '0);

    // Window as it will look once the byte in the shift register is accepted.
    generate
        if (PATLEN > 1) begin : g_hist
            assign window = {hist_reg, shift_reg};
        end else begin : g_nohist
            assign window = shift_reg;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < PATLEN; gi++) begin : g_cmp
            assign byte_eq[gi] = (fold(window[8*gi +: 8]) == fold(PATTERN[8*gi +: 8]));
        end
    endgenerate

    assign hist_eq  = &byte_eq;
    assign fill_sat = (fill_reg == FW'(PATLEN)) ? fill_reg : fill_reg + FW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bits_reg     <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            rcv_reg      <= 1'b0;
            match_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
            hist_reg     <= '0;
            fill_reg     <= '0;
        end else begin
            rx_meta_reg  <= rx;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bits_reg     <= bits_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            rcv_reg      <= rcv_next;
            match_reg    <= match_next;
            ferr_reg     <= ferr_next;
            hist_reg     <= hist_next;
            fill_reg     <= fill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = tick ? FULL : cnt_reg - CW'(1);
        bits_next  = bits_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        rcv_next   = 1'b0;
        match_next = 1'b0;
        ferr_next  = 1'b0;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        case (state_reg)
            IDLE: begin
                // Aim the first tick at the middle of the start bit.
                if (rxs_prev_reg && !rxs_reg) begin
                    cnt_next   = HALF;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    bits_next  = '0;
                    state_next = rxs_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = {rxs_reg, shift_reg[7:1]};
                    bits_next  = bits_reg + 3'd1;
                    if (bits_reg == 3'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rxs_reg) begin
                        data_next  = shift_reg;
                        rcv_next   = 1'b1;
                        hist_next  = window[HW-1:0];
                        fill_next  = fill_sat;
                        match_next = (fill_sat == FW'(PATLEN)) && hist_eq;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Sit out a held-low line so it cannot produce repeated frames.
                if (rxs_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign data  = data_reg;
    assign rcv   = rcv_reg;
    assign match = match_reg;
    assign ferr  = ferr_reg;
    assign busy  = (state_reg != IDLE);

endmodule
